// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between the control path and alu_seq.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

interface alu_seq_if #(
    parameter int WIDTH = `WORD_SIZE
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequences accumulator ops through an external combinational ALU,
// with valid/ready request and response handshakes and sticky status flags.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module alu_seq #(
    parameter int WIDTH = `WORD_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    alu_seq_if.slave         bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_mode,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_ovf,
    output logic [WIDTH-1:0] acc,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);
    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_CLRF = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_n;
    logic   ovf;
    logic   accept;
    logic   arith;

    assign accept = (state == IDLE) && bus.req_valid;
    assign arith  = (bus.req_op == OP_ADD) || (bus.req_op == OP_SUB);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.req_valid ? (arith ? EXEC : RESP) : IDLE;
            EXEC:    state_n = RESP;
            RESP:    state_n = bus.rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    // alu_a is a registered mirror of acc, written on the same edges as acc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= 1'b0;
            ovf      <= 1'b0;
            flag_v   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                if (arith) begin
                    alu_b    <= bus.req_data;
                    alu_mode <= (bus.req_op == OP_SUB);
                end else begin
                    ovf <= 1'b0;
                    if (bus.req_op == OP_LOAD) begin
                        acc   <= bus.req_data;
                        alu_a <= bus.req_data;
                    end
                    if (bus.req_op == OP_CLRF)
                        flag_v <= 1'b0;
                end
            end
            if (state == EXEC) begin
                acc    <= alu_c;
                alu_a  <= alu_c;
                ovf    <= alu_ovf;
                flag_v <= flag_v | alu_ovf;
            end
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = acc;
    assign bus.rsp_ovf   = ovf;
    assign flag_z        = (acc == '0);
    assign flag_n        = acc[WIDTH-1];
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq with a behavioural 8-bit ALU attached.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] alu_a, alu_b, alu_c, acc;
    logic         alu_mode, alu_ovf, flag_z, flag_n, flag_v;
    int           checks = 0;
    int           errors = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_c(alu_c), .alu_ovf(alu_ovf),
        .acc(acc), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    // signed overflow: operands of matching (add) or differing (sub) sign, result sign flips
    assign alu_c   = alu_mode ? alu_a - alu_b : alu_a + alu_b;
    assign alu_ovf = (alu_mode ? (alu_a[W-1] != alu_b[W-1]) : (alu_a[W-1] == alu_b[W-1]))
                     && (alu_c[W-1] != alu_a[W-1]);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] data);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic finish(input string tag, input logic [W-1:0] exp_data, input logic exp_ovf,
                          input int exp_lat);
        int lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, bus.rsp_data, exp_data);
        check({tag, "_ovf"}, bus.rsp_ovf, exp_ovf);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check({tag, "_ready"}, bus.req_ready, 1);
    endtask

    task automatic txn(input string tag, input logic [2:0] op, input logic [W-1:0] data,
                       input logic [W-1:0] exp_data, input logic exp_ovf, input int exp_lat);
        send(op, data);
        finish(tag, exp_data, exp_ovf, exp_lat);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        #12;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_acc", acc, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_mode", alu_mode, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_ovf", bus.rsp_ovf, 0);
        check("rst_flags", {flag_v, flag_z, flag_n}, 3'b010);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        txn("load100", 3'd0, 8'd100, 8'd100, 1'b0, 1);
        txn("add27", 3'd1, 8'd27, 8'd127, 1'b0, 2);
        check("add27_v", flag_v, 0);

        txn("add1", 3'd1, 8'd1, 8'h80, 1'b1, 2);
        check("add1_vn", {flag_v, flag_n}, 2'b11);
        txn("read", 3'd3, 8'd55, 8'h80, 1'b0, 1);
        check("read_v", flag_v, 1);

        txn("sub1", 3'd2, 8'd1, 8'h7f, 1'b1, 2);
        txn("clrf", 3'd4, 8'd0, 8'h7f, 1'b0, 1);
        check("clrf_v", flag_v, 0);
        check("clrf_acc", acc, 8'h7f);
        txn("nop", 3'd6, 8'd3, 8'h7f, 1'b0, 1);

        txn("load5", 3'd0, 8'd5, 8'd5, 1'b0, 1);
        send(3'd2, 8'd5);
        check("exec_a", alu_a, 5);
        check("exec_b", alu_b, 5);
        check("exec_mode", alu_mode, 1);
        check("exec_req_ready", bus.req_ready, 0);
        finish("sub5", 8'd0, 1'b0, 2);
        check("sub5_z", flag_z, 1);

        send(3'd1, 8'd3);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_data  = 8'd9;
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_data", bus.rsp_data, 3);
            check("stall_req_ready", bus.req_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check("stall_acc", acc, 3);
        send(3'd0, 8'd9);
        finish("load9", 8'd9, 1'b0, 1);

        send(3'd1, 8'd5);
        #2 rst = 1'b1;
        #1;
        check("abort_acc", acc, 0);
        check("abort_alu_a", alu_a, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_req_ready", bus.req_ready, 1);
        @(negedge clk) rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1 check("abort_no_rsp", bus.rsp_valid, 0);
        end
        txn("read0", 3'd3, 8'd0, 8'd0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequencing front end for the combinational ALU. It accepts operation requests over a valid/ready handshake and owns the accumulator register. It drives the ALU operand and mode inputs, captures the ALU result and overflow one cycle later, and returns each result over a second valid/ready handshake. It sits between the instruction/control path and the `alu` instance. It also keeps sticky status flags for the control path.

## Interface
- WIDTH, default `WORD_SIZE: datapath width. All data is signed two's complement.
- clk  in  1  sole clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request. Equals (state==IDLE).
- req_op  in  3  0 LOAD, 1 ADD, 2 SUB, 3 READ, 4 CLRF. Codes 5-7 are NOP.
- req_data  in  WIDTH  operand. Used by LOAD, ADD and SUB; ignored otherwise.
- rsp_valid  out  1  response present. Equals (state==RESP).
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  accumulator value after the operation.
- rsp_ovf  out  1  overflow of this operation. Always 0 for non-arithmetic ops.
- alu_a  out  WIDTH  to ALU `a`. Registered; equals acc.
- alu_b  out  WIDTH  to ALU `b`. Registered operand.
- alu_mode  out  1  to ALU mode. 0 = ADD, 1 = SUB. Registered.
- alu_c  in  WIDTH  ALU result.
- alu_ovf  in  1  ALU overflow.
- acc  out  WIDTH  accumulator.
- flag_z  out  1  acc == 0.
- flag_n  out  1  acc[WIDTH-1].
- flag_v  out  1  sticky overflow.

## Operation
- FSM has three states: IDLE, EXEC, RESP. The reset state is IDLE.
- IDLE: a request is accepted when req_valid && req_ready at a rising edge.
  - ADD or SUB: latch req_data into alu_b, set alu_mode (ADD→0, SUB→1), go to EXEC.
  - LOAD: acc ← req_data, rsp_ovf ← 0, go to RESP.
  - READ or NOP: acc unchanged, rsp_ovf ← 0, go to RESP.
  - CLRF: flag_v ← 0, acc unchanged, rsp_ovf ← 0, go to RESP.
- EXEC lasts exactly one cycle.
  - alu_a, alu_b and alu_mode are stable for the whole cycle.
  - On the closing edge: acc ← alu_c, rsp_ovf ← alu_ovf, flag_v ← flag_v | alu_ovf. Go to RESP.
- RESP: rsp_data = acc and rsp_ovf are held stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready, return to IDLE. A new request can be accepted the cycle after.
- alu_a tracks acc. It is a register updated whenever acc is written, never a combinational copy.
- Outside EXEC, alu_b and alu_mode hold their last values.
- flag_z and flag_n are combinational from acc.
- flag_v clears only on CLRF or reset.
- Arithmetic wraps modulo 2^WIDTH. No saturation; overflow is reported only via alu_ovf.
- Every accepted request produces exactly one response, in order.

## Timing
- Reset values while rst=1 and after release:
  - state IDLE, so req_ready=1 and rsp_valid=0.
  - acc, alu_a, alu_b, rsp_data = 0; alu_mode=0; rsp_ovf=0.
  - flag_v=0, flag_z=1, flag_n=0.
- Latency, with the request accepted at edge N:
  - LOAD, READ, CLRF, NOP: rsp_valid high in the cycle after N.
  - ADD, SUB: rsp_valid high in the cycle after N+1.
- Throughput: one arithmetic op per 3 cycles, one non-arithmetic op per 2 cycles, with rsp_ready tied high.
- req_ready is low in EXEC and RESP. A req_valid held then is not consumed and must not affect state.
- req_valid and rsp_ready are sampled only at rising edges. No combinational path from req_valid to req_ready or from rsp_ready to rsp_valid.
- Reset asserted mid-operation (EXEC or RESP) aborts it immediately. No response is produced, and registers take reset values asynchronously.
- Back-to-back: LOAD followed immediately by ADD uses the new acc. alu_a is updated on the same edge as acc.

## Test plan
All scenarios use WIDTH=8.
- Reset, then LOAD 100, then ADD 27 → two responses, 100 then 127. rsp_ovf=0 on both, flag_v=0, ADD latency 2 cycles.
- From acc=127, ADD 1 → rsp_data=-128, rsp_ovf=1, flag_v=1, flag_n=1. Then READ → rsp_data=-128, rsp_ovf=0, flag_v stays 1.
- From acc=-128, SUB 1 → rsp_data=127 and rsp_ovf=1. Then CLRF → flag_v=0, acc=127.
- LOAD 5, SUB 5 → rsp_data=0, flag_z=1, rsp_ovf=0. While in EXEC, alu_a=5, alu_b=5, alu_mode=1.
- ADD 3 with rsp_ready held low for 4 cycles → rsp_valid and rsp_data stay stable, req_ready=0 throughout, and a req_valid LOAD 9 presented meanwhile is ignored. After the handshake, LOAD 9 is accepted.
- ADD issued, then rst asserted during EXEC → acc=0, rsp_valid=0, req_ready=1 with no response emitted. A subsequent READ returns 0.
